// File: rtl/uart_reg_arbiter_if.sv
// Bundles the requester-side and uart_top-side register port signals of uart_reg_arbiter.
// The master modport is the environment (requesters + uart_top); the slave modport is the arbiter.
interface uart_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_wr_en;
  logic [NUM_REQ-1:0]        req_rd_en;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_err;
  logic                      uart_reg_wr_en;
  logic                      uart_reg_rd_en;
  logic [ADDR_W-1:0]         uart_reg_addr;
  logic [DATA_W-1:0]         uart_reg_wdata;
  logic [DATA_W-1:0]         uart_reg_rdata;
  logic                      uart_ready;
  logic                      busy;
  logic [2:0]                grant_id;

  modport master (
    output req_wr_en, req_rd_en, req_addr, req_wdata, uart_reg_rdata, uart_ready,
    input  req_rdata, req_ready, req_err, uart_reg_wr_en, uart_reg_rd_en,
           uart_reg_addr, uart_reg_wdata, busy, grant_id
  );

  modport slave (
    input  req_wr_en, req_rd_en, req_addr, req_wdata, uart_reg_rdata, uart_ready,
    output req_rdata, req_ready, req_err, uart_reg_wr_en, uart_reg_rd_en,
           uart_reg_addr, uart_reg_wdata, busy, grant_id
  );
endinterface

// File: rtl/uart_reg_arbiter.sv
// Round-robin arbiter sharing the single uart_top register port among NUM_REQ requesters,
// one transaction in flight, with a GRANT-state timeout for accesses uart_top never acknowledges.
module uart_reg_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  uart_reg_arbiter_if.slave  bus
);
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

  state_e             state_q;
  logic               wr_en_q, rd_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] ready_q, err_q;
  logic [TW-1:0]      tmo_q;
  logic [2:0]         rr_ptr_q, grant_q;
  logic               busy_q;

  logic [7:0]         pend8, wr8;
  logic [3:0]         cand;
  logic               found;
  logic [2:0]         win_idx;
  logic               win_wr;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  // First pending requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pend8   = 8'(bus.req_wr_en | bus.req_rd_en);
    wr8     = 8'(bus.req_wr_en);
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 4'(rr_ptr_q) + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && pend8[cand[2:0]]) begin
        found   = 1'b1;
        win_idx = cand[2:0];
      end
    end
    win_wr    = wr8[win_idx];
    win_addr  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_wdata = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= '0;
      err_q    <= '0;
      tmo_q    <= '0;
      rr_ptr_q <= 3'(NUM_REQ - 1);
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          // A ready still high from the previous access must fall before a new grant.
          if (found && !bus.uart_ready) begin
            wr_en_q  <= win_wr;
            rd_en_q  <= !win_wr;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            grant_q  <= win_idx;
            rr_ptr_q <= win_idx;
            tmo_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (bus.uart_ready) begin
            rdata_q <= bus.uart_reg_rdata;
            ready_q <= NUM_REQ'(1) << grant_q;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            state_q <= RELEASE;
          end else if (TIMEOUT_CYC != 0 && tmo_q == TMO_LAST) begin
            rdata_q <= '0;
            ready_q <= NUM_REQ'(1) << grant_q;
            err_q   <= NUM_REQ'(1) << grant_q;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            state_q <= RELEASE;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.uart_ready) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.uart_reg_wr_en = wr_en_q;
  assign bus.uart_reg_rd_en = rd_en_q;
  assign bus.uart_reg_addr  = addr_q;
  assign bus.uart_reg_wdata = wdata_q;
  assign bus.req_rdata      = rdata_q;
  assign bus.req_ready      = ready_q;
  assign bus.req_err        = err_q;
  assign bus.busy           = busy_q;
  assign bus.grant_id       = grant_q;
endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Directed testbench for uart_reg_arbiter: two requesters, TIMEOUT_CYC=8, hand-computed expectations.
module tb_uart_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_reg_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  uart_reg_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Waits (bounded) for an enable, acks it on the next edge, then drops the granted request.
  task automatic service(input logic [31:0] rdat, output logic [2:0] gid, output logic [1:0] rdy,
                         output logic [31:0] rdout, output logic [31:0] aout, output logic wr,
                         output logic ok);
    ok = 1'b0; gid = '0; rdy = '0; rdout = '0; aout = '0; wr = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.uart_reg_wr_en || bus.uart_reg_rd_en) ok = 1'b1;
    end
    if (ok) begin
      gid = bus.grant_id; aout = bus.uart_reg_addr; wr = bus.uart_reg_wr_en;
      bus.uart_ready = 1'b1; bus.uart_reg_rdata = rdat;
      @(negedge clk);
      rdy = bus.req_ready; rdout = bus.req_rdata;
      bus.req_wr_en[gid[0]] = 1'b0; bus.req_rd_en[gid[0]] = 1'b0;
      bus.uart_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    bus.req_wr_en = '0; bus.req_rd_en = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.uart_reg_rdata = '0; bus.uart_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.uart_reg_wr_en, bus.uart_reg_rd_en} !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b want 00", {bus.uart_reg_wr_en, bus.uart_reg_rd_en}); end
    n_cmp++; if ({bus.uart_reg_addr, bus.uart_reg_wdata, bus.req_rdata} !== 96'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {bus.uart_reg_addr, bus.uart_reg_wdata, bus.req_rdata}); end
    n_cmp++; if ({bus.req_ready, bus.req_err, bus.busy, bus.grant_id} !== 8'h00) begin n_err++; $display("FAIL reset_ctl: got %h want 00", {bus.req_ready, bus.req_err, bus.busy, bus.grant_id}); end
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    bus.req_addr[31:0] = 32'h0; bus.req_wdata[31:0] = 32'h4000_0036; bus.req_wr_en[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.uart_reg_wr_en, bus.uart_reg_rd_en, bus.busy} !== 3'b101) begin n_err++; $display("FAIL wr_enable: got %b want 101", {bus.uart_reg_wr_en, bus.uart_reg_rd_en, bus.busy}); end
    n_cmp++; if (bus.uart_reg_wdata !== 32'h4000_0036) begin n_err++; $display("FAIL wr_wdata: got %h want 40000036", bus.uart_reg_wdata); end
    n_cmp++; if (bus.uart_reg_addr !== 32'h0 || bus.grant_id !== 3'd0) begin n_err++; $display("FAIL wr_addr_gid: got %h/%0d want 0/0", bus.uart_reg_addr, bus.grant_id); end
    bus.uart_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.req_ready, bus.req_err, bus.uart_reg_wr_en} !== 5'b01000) begin n_err++; $display("FAIL wr_ack: got %b want 01000", {bus.req_ready, bus.req_err, bus.uart_reg_wr_en}); end
    bus.req_wr_en[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.req_ready, bus.busy} !== 3'b001) begin n_err++; $display("FAIL wr_release: got %b want 001", {bus.req_ready, bus.busy}); end
    bus.uart_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    logic [2:0] g; logic [1:0] r; logic [31:0] d, a; logic w, ok;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.req_addr = {32'h0C, 32'h08}; bus.req_wdata = {32'h11, 32'h0};
    bus.req_rd_en[0] = 1'b1; bus.req_wr_en[1] = 1'b1;
    service(32'h33, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r, w} !== 7'b1_000_01_0 || a !== 32'h08 || d !== 32'h33) begin n_err++; $display("FAIL rr_first: got ok%b g%0d r%b w%b a%h d%h want ok1 g0 r01 w0 a08 d33", ok, g, r, w, a, d); end
    service(32'h0, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r, w} !== 7'b1_001_10_1 || a !== 32'h0C || bus.uart_reg_wdata !== 32'h11) begin n_err++; $display("FAIL rr_second: got ok%b g%0d r%b w%b a%h want ok1 g1 r10 w1 a0c", ok, g, r, w, a); end
    bus.req_rd_en[0] = 1'b1;
    service(32'h0, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r} !== 6'b1_000_01) begin n_err++; $display("FAIL rr_solo: got ok%b g%0d r%b want ok1 g0 r01", ok, g, r); end
    bus.req_rd_en[0] = 1'b1; bus.req_wr_en[1] = 1'b1;
    service(32'h0, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r} !== 6'b1_001_10) begin n_err++; $display("FAIL rr_rot_first: got ok%b g%0d r%b want ok1 g1 r10", ok, g, r); end
    service(32'h0, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r} !== 6'b1_000_01) begin n_err++; $display("FAIL rr_rot_second: got ok%b g%0d r%b want ok1 g0 r01", ok, g, r); end
  endtask

  task automatic test_read_data;
    logic [2:0] g; logic [1:0] r; logic [31:0] d, a; logic w, ok;
    bus.req_addr[63:32] = 32'h04; bus.req_rd_en[1] = 1'b1;
    service(32'h0000_005A, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r, w} !== 7'b1_001_10_0 || a !== 32'h04) begin n_err++; $display("FAIL rd_grant: got ok%b g%0d r%b w%b a%h want ok1 g1 r10 w0 a04", ok, g, r, w, a); end
    n_cmp++; if (d !== 32'h0000_005A) begin n_err++; $display("FAIL rd_data: got %h want 0000005a", d); end
  endtask

  task automatic test_timeout;
    int cnt; logic seen;
    cnt = 0; seen = 1'b0;
    bus.req_addr[63:32] = 32'h04; bus.req_rd_en[1] = 1'b1; bus.uart_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.uart_reg_rd_en) begin seen = 1'b1; cnt++; end
      else if (seen) break;
    end
    n_cmp++; if (cnt !== 8) begin n_err++; $display("FAIL tmo_hold: got %0d cycles want 8", cnt); end
    n_cmp++; if ({bus.req_ready, bus.req_err, bus.uart_reg_rd_en} !== 5'b10100) begin n_err++; $display("FAIL tmo_pulse: got %b want 10100", {bus.req_ready, bus.req_err, bus.uart_reg_rd_en}); end
    n_cmp++; if (bus.req_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_rdata: got %h want 0", bus.req_rdata); end
    bus.req_rd_en[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.req_ready, bus.req_err} !== 4'b0000) begin n_err++; $display("FAIL tmo_single: got %b want 0000", {bus.req_ready, bus.req_err}); end
    @(negedge clk);
  endtask

  task automatic test_stale_ready;
    logic ok; logic stray;
    ok = 1'b0; stray = 1'b0;
    bus.req_wdata[31:0] = 32'h11; bus.req_wr_en[0] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.uart_reg_wr_en) ok = 1'b1;
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stale_first_grant: got %b want 1", ok); end
    bus.uart_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL stale_ack: got %b want 01", bus.req_ready); end
    bus.req_wdata[31:0] = 32'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.uart_reg_wr_en || !bus.busy) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL stale_no_enable: got %b want 0", stray); end
    bus.uart_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.uart_reg_wr_en !== 1'b0) begin n_err++; $display("FAIL stale_idle: got %b want 0", bus.uart_reg_wr_en); end
    @(negedge clk);
    n_cmp++; if ({bus.uart_reg_wr_en, bus.grant_id} !== 4'b1000 || bus.uart_reg_wdata !== 32'h22) begin n_err++; $display("FAIL stale_regrant: got %b/%h want 1000/22", {bus.uart_reg_wr_en, bus.grant_id}, bus.uart_reg_wdata); end
    bus.uart_ready = 1'b1; bus.uart_reg_rdata = 32'h77;
    @(negedge clk);
    bus.req_wr_en[0] = 1'b0; bus.uart_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [2:0] g; logic [1:0] r; logic [31:0] d, a; logic w, ok;
    ok = 1'b0;
    bus.req_wr_en[0] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.uart_reg_wr_en) ok = 1'b1;
    end
    n_cmp++; if (ok !== 1'b1 || bus.req_rdata !== 32'h77) begin n_err++; $display("FAIL rstmid_pre: got ok%b rdata %h want ok1 77", ok, bus.req_rdata); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.uart_reg_wr_en, bus.uart_reg_rd_en, bus.busy, bus.grant_id, bus.req_ready, bus.req_err} !== 10'b0) begin n_err++; $display("FAIL rstmid_ctl: got %b want 0", {bus.uart_reg_wr_en, bus.uart_reg_rd_en, bus.busy, bus.grant_id, bus.req_ready, bus.req_err}); end
    n_cmp++; if ({bus.uart_reg_addr, bus.uart_reg_wdata, bus.req_rdata} !== 96'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", {bus.uart_reg_addr, bus.uart_reg_wdata, bus.req_rdata}); end
    bus.uart_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.uart_ready = 1'b0; bus.req_wr_en[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.req_ready, bus.req_err, bus.busy} !== 5'b0) begin n_err++; $display("FAIL rstmid_no_pulse: got %b want 0", {bus.req_ready, bus.req_err, bus.busy}); end
    bus.req_addr[63:32] = 32'h0C; bus.req_rd_en[1] = 1'b1;
    service(32'h5, g, r, d, a, w, ok);
    n_cmp++; if ({ok, g, r} !== 6'b1_001_10 || d !== 32'h5 || a !== 32'h0C) begin n_err++; $display("FAIL rstmid_after: got ok%b g%0d r%b d%h a%h want ok1 g1 r10 d5 a0c", ok, g, r, d, a); end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_read_data;
    test_timeout;
    test_stale_ready;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
endmodule
